// File: rtl/lvds_rx_align.sv
// Word-boundary aligner for an LVDS deserializer: bitslips until the training word is seen.
// States: IDLE outputs off | CHECK compare training word | SLIP bitslip pulse | WAIT settle | LOCKED aligned.
module lvds_rx_align #(
    parameter logic [7:0] TRAIN_PATTERN = 8'hF0,
    parameter int         LOCK_COUNT    = 16,
    parameter int         SLIP_WAIT     = 4,
    parameter int         MAX_SLIPS     = 8,
    parameter int         ERR_LIMIT     = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clk_locked,
    input  logic       train_en,
    input  logic [7:0] rx_out,
    output logic       rx_data_align,
    output logic       aligned,
    output logic       align_err,
    output logic [3:0] slip_count,
    output logic [7:0] data_out,
    output logic       data_valid
);

    localparam int MATCH_W = $clog2(LOCK_COUNT + 1);
    localparam int ERR_W   = $clog2(ERR_LIMIT + 1);
    localparam int WAIT_W  = $clog2(SLIP_WAIT + 1);
    localparam int SLIP_W  = $clog2(MAX_SLIPS + 1);

    localparam logic [MATCH_W-1:0] MATCH_FULL = MATCH_W'(LOCK_COUNT);
    localparam logic [MATCH_W-1:0] MATCH_LAST = MATCH_W'(LOCK_COUNT - 1);
    localparam logic [ERR_W-1:0]   ERR_LAST   = ERR_W'(ERR_LIMIT - 1);
    localparam logic [WAIT_W-1:0]  WAIT_LOAD  = WAIT_W'(SLIP_WAIT - 1);
    localparam logic [SLIP_W-1:0]  SLIP_LAST  = SLIP_W'(MAX_SLIPS - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CHECK,
        ST_SLIP,
        ST_WAIT,
        ST_LOCKED
    } state_t;

    state_t              state_q, state_d;
    logic [7:0]          rx_q;
    logic [MATCH_W-1:0]  match_q, match_d;
    logic [ERR_W-1:0]    err_q, err_d;
    logic [WAIT_W-1:0]   wait_q, wait_d;
    logic [SLIP_W-1:0]   slip_q, slip_d;
    logic                align_err_q, align_err_d;
    logic                aligned_q, aligned_d;
    logic                pulse_q, pulse_d;
    logic                word_ok;

    assign word_ok = (rx_q == TRAIN_PATTERN);

    always_comb begin
        state_d     = state_q;
        match_d     = match_q;
        err_d       = err_q;
        wait_d      = wait_q;
        slip_d      = slip_q;
        align_err_d = align_err_q;
        aligned_d   = aligned_q;
        pulse_d     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                aligned_d = 1'b0;
                if (clk_locked && train_en) begin
                    state_d     = ST_CHECK;
                    match_d     = '0;
                    err_d       = '0;
                    slip_d      = '0;
                    align_err_d = 1'b0;
                end
            end
            ST_CHECK: begin
                if (train_en) begin
                    if (word_ok) begin
                        if (match_q != MATCH_FULL) match_d = match_q + 1'b1;
                        if (match_q == MATCH_LAST) begin
                            state_d   = ST_LOCKED;
                            aligned_d = 1'b1;
                        end
                    end else begin
                        // Pulse and slip count update together, so slip_count is valid during SLIP.
                        match_d = '0;
                        state_d = ST_SLIP;
                        pulse_d = 1'b1;
                        if (slip_q == SLIP_LAST) begin
                            slip_d      = '0;
                            align_err_d = 1'b1;
                        end else begin
                            slip_d = slip_q + 1'b1;
                        end
                    end
                end
            end
            ST_SLIP: begin
                state_d = ST_WAIT;
                wait_d  = WAIT_LOAD;
            end
            ST_WAIT: begin
                if (wait_q == '0) state_d = ST_CHECK;
                else              wait_d  = wait_q - 1'b1;
            end
            ST_LOCKED: begin
                if (train_en) begin
                    if (word_ok) begin
                        err_d = '0;
                    end else if (err_q == ERR_LAST) begin
                        state_d   = ST_CHECK;
                        aligned_d = 1'b0;
                        err_d     = '0;
                        match_d   = '0;
                    end else begin
                        err_d = err_q + 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (!clk_locked) begin
            state_d   = ST_IDLE;
            aligned_d = 1'b0;
            pulse_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            rx_q        <= '0;
            match_q     <= '0;
            err_q       <= '0;
            wait_q      <= '0;
            slip_q      <= '0;
            align_err_q <= 1'b0;
            aligned_q   <= 1'b0;
            pulse_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            rx_q        <= rx_out;
            match_q     <= match_d;
            err_q       <= err_d;
            wait_q      <= wait_d;
            slip_q      <= slip_d;
            align_err_q <= align_err_d;
            aligned_q   <= aligned_d;
            pulse_q     <= pulse_d;
        end
    end

    assign rx_data_align = pulse_q;
    assign aligned       = aligned_q;
    assign align_err     = align_err_q;
    assign slip_count    = 4'(slip_q);
    assign data_out      = rx_q;
    assign data_valid    = aligned_q;

endmodule
